// File: rtl/tinyrisc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tinyrisc_pkg                                                  |
// | Brief    : Shared TinyRISC types for the execute-stage mul/div unit.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package tinyrisc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_MOD = 2'd2
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Decoder flag priority: multiply wins over divide, divide over modulo.
    function automatic md_op_t selectOp(input logic isMul, input logic isDiv);
        if (isMul)
            return MD_MUL;
        else if (isDiv)
            return MD_DIV;
        else
            return MD_MOD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : muldiv_core                                                   |
// | Brief    : Iterative magnitude shift-add / restoring-division datapath.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module muldiv_core
    import tinyrisc_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_magA;
    logic [WIDTH-1:0]   r_magB;
    logic               r_negA;
    logic               r_negB;

    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;

    assign w_magA = a[WIDTH-1] ? -a : a;
    assign w_magB = b[WIDTH-1] ? -b : b;

    // Multiply: upper half accumulates the multiplicand, the pair shifts right.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_magA};
    // Divide: trial subtraction of the divisor from the left-shifted partial remainder.
    assign w_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_magB};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_magA <= '0;
            r_magB <= '0;
            r_negA <= 1'b0;
            r_negB <= 1'b0;
        end else if (load) begin
            r_negA <= a[WIDTH-1];
            r_negB <= b[WIDTH-1];
            r_magA <= w_magA;
            r_magB <= w_magB;
            r_acc  <= {{WIDTH{1'b0}}, (op == MD_MUL) ? w_magB : w_magA};
        end else if (step) begin
            if (op == MD_MUL)
                r_acc <= r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                  : {1'b0, r_acc[2*WIDTH-1:1]};
            else
                r_acc <= w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    assign w_lo = r_acc[WIDTH-1:0];
    assign w_hi = r_acc[2*WIDTH-1:WIDTH];

    // A zero divisor yields an all-ones quotient regardless of the dividend sign.
    assign product   = (r_negA ^ r_negB) ? -w_lo : w_lo;
    assign quotient  = (r_magB == '0) ? '1 : ((r_negA ^ r_negB) ? -w_lo : w_lo);
    assign remainder = r_negA ? -w_hi : w_hi;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : muldiv_sequencer                                              |
// | Brief    : Start/busy/done FSM around the iterative mul/div/mod core.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module muldiv_sequencer
    import tinyrisc_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             isMul,
    input  logic             isDiv,
    input  logic             isMod,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_lastIter = CNT_W'(WIDTH - 1);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_count;
    md_op_t           r_op;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic             w_opValid;
    logic             w_request;
    logic             w_load;
    md_op_t           w_selOp;
    md_op_t           w_coreOp;
    logic [WIDTH-1:0] w_product;
    logic [WIDTH-1:0] w_quotient;
    logic [WIDTH-1:0] w_remainder;
    logic [WIDTH-1:0] w_fixResult;

    assign w_opValid = isMul | isDiv | isMod;
    assign w_request = start & w_opValid & (r_state == IDLE);
    // A flush in IDLE drops a simultaneous start even though stall still reflects it.
    assign w_load    = w_request & ~flush;
    assign w_selOp   = selectOp(isMul, isDiv);
    assign w_coreOp  = (r_state == IDLE) ? w_selOp : r_op;

    muldiv_core #(
        .WIDTH     (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .step      (r_state == CALC),
        .op        (w_coreOp),
        .a         (a),
        .b         (b),
        .product   (w_product),
        .quotient  (w_quotient),
        .remainder (w_remainder)
    );

    always_comb begin
        w_fixResult = w_product;
        case (r_op)
            MD_DIV:  w_fixResult = w_quotient;
            MD_MOD:  w_fixResult = w_remainder;
            default: w_fixResult = w_product;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_op     <= MD_MUL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush && (r_state != IDLE)) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_load) begin
                        r_state <= CALC;
                        r_count <= '0;
                        r_op    <= w_selOp;
                        r_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == c_lastIter)
                        r_state <= FIX;
                end
                FIX: begin
                    r_result <= w_fixResult;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_count <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign stall  = w_request | r_busy;

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multi-cycle multiply/divide/modulo unit with its own sequencing FSM for the TinyRISC execute stage. The decoder's `isMul`, `isDiv` and `isMod` flags launch an operation. The block stalls the pipeline through a start/busy/done handshake while a shift-add or restoring-division datapath iterates, then returns one 32-bit result. The result follows SimpleRISC signed semantics.

## Interface
- `WIDTH`, default 32: operand and result width. The iteration count equals `WIDTH`.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request from the EX stage. It is sampled only in `IDLE`.
- `isMul`, `isDiv`, `isMod`  in  1 each: decoder flags that select the operation.
- `flush`  in  1: aborts any operation in progress.
- `a`  in  WIDTH: operand A, the multiplicand or the dividend, signed.
- `b`  in  WIDTH: operand B, the multiplier or the divisor, signed.
- `busy`  out  1: high in `CALC` and `FIX`.
- `stall`  out  1: combinational. It equals `(start & op_valid & state==IDLE) | busy`, where `op_valid` is `isMul | isDiv | isMod`.
- `done`  out  1: one-cycle pulse in `DONE`.
- `result`  out  WIDTH: registered result. It holds its value until the next accepted start.

## Operation
- **Acceptance:**
  - A start is accepted when `start`, `op_valid` and `state==IDLE` are all true.
  - `start` without any operation flag is ignored.
  - If several flags are set, priority is `isMul` > `isDiv` > `isMod`.
  - On acceptance the block latches `a` and `b` and the selected operation. The operands may change after that cycle.
- **States:**
  - `IDLE` goes to `CALC` on an accepted start.
  - `CALC` runs `WIDTH` iterations, one per cycle, using a counter from 0 to `WIDTH-1`. After the last iteration it goes to `FIX`.
  - `FIX` applies the sign correction and writes `result`, then goes to `DONE`.
  - `DONE` asserts `done` and returns to `IDLE`.
- **MUL:** magnitude shift-add. `result` = low `WIDTH` bits of the signed product. Negate when the operand signs differ.
- **DIV/MOD:** restoring division on magnitudes, so the quotient truncates toward zero.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of `a`.
  - DIV returns the quotient. MOD returns the remainder.
- **Divide by zero** (`b==0`): DIV returns all ones and MOD returns `a` unchanged. `done` timing is the same as any other operation.
- **Overflow** (`a==INT_MIN` and `b==-1`): DIV returns `INT_MIN` and MOD returns 0. This falls out of the natural `WIDTH`-bit wrap of the magnitude algorithm.
- **Start while not `IDLE`:** ignored. It is not queued.
- **`flush` in any state other than `IDLE`:**
  - Next state is `IDLE`.
  - `done` is not asserted and `result` is not updated.
  - `flush` takes priority over the state transition in the same cycle.
  - When `flush` and `start` are both high in `IDLE`, the start is dropped.
- **Reset:** `rst_n` low at any edge, including mid-operation, sets:
  - state = `IDLE`, counter = 0;
  - `busy` = 0, `done` = 0, `result` = 0;
  - the internal operand and accumulator registers = 0;
  - `stall` therefore reads 0 while `start` is low.

## Timing
- Start is accepted in cycle N.
- `CALC` occupies cycles N+1 to N+WIDTH.
- `FIX` is cycle N+WIDTH+1.
- `DONE` is cycle N+WIDTH+2, which is N+34 for `WIDTH`=32. `done` is high for exactly that one cycle and `result` is valid from then on.
- `stall` is high from cycle N through N+WIDTH+1 inclusive and low in the `DONE` cycle, so EX captures `result` on that edge.
- The earliest back-to-back start is cycle N+WIDTH+3, the first cycle back in `IDLE`.
- `busy` is low in `IDLE` and `DONE`.

## Structure
- Shared package `tinyrisc_pkg` holds:
  - the `WORD_W`=32 constant;
  - the `md_op_t` enum: `MD_MUL`, `MD_DIV`, `MD_MOD`;
  - the `md_state_t` enum: `IDLE`, `CALC`, `FIX`, `DONE`.
- `muldiv_sequencer` owns the FSM, the iteration counter, the flush/reset logic and the `result` register.
- Sub-module `muldiv_core` is the iterative datapath. Its interface:
  - inputs `load`, `step` and `op`;
  - 2×`WIDTH` accumulator, the magnitude registers and the sign flags;
  - outputs the sign-corrected product, quotient and remainder, presented in `FIX`.

## Test plan
- MUL: a=7, b=-3 (0xFFFFFFFD), start at N → `done` only at N+34, `result`=0xFFFFFFEB, `stall` high N..N+33.
- DIV/MOD signed: a=-17, b=5 → DIV 0xFFFFFFFD (-3), MOD 0xFFFFFFFE (-2); a=17, b=-5 → DIV 0xFFFFFFFD, MOD 2.
- Divide by zero: a=100, b=0 → DIV 0xFFFFFFFF, MOD 100 (0x64); INT_MIN/-1 → DIV 0x80000000, MOD 0.
- Handshake: start pulsed again at N+5 with different operands → ignored and the first result is unchanged. Start with no flags → `stall`/`busy` stay 0. `isMul` and `isDiv` both set → product returned.
- Flush at N+10 → `IDLE` at N+11, no `done`, `result` keeps its previous value. New start at N+11 is accepted and `done` comes at N+45.
- Reset: `rst_n` low at N+20 for one cycle → `busy`, `done` and `result` are 0 on the next cycle. A subsequent start produces a correct result 34 cycles later.
